if_stage: RTL and testbench

Instruction-fetch stage of the single-issue LEGv8 pipeline: owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register consumed by decode. Handles hazard stalls, branch redirect with flush, halt, and target-alignment checking. Sits between the branch/hazard logic (control inputs) and the decode stage (IF/ID outputs).

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem and registers IF/ID.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/bubble performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        misalign_err,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        do_branch_s;
    logic        do_halt_s;
    logic        do_fetch_s;
    logic [31:0] pc_r;
    logic        valid_r;
    logic [31:0] ipc_r;
    logic [31:0] instr_r;
    logic        err_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a redirect in the same cycle swallows the halt request
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!branch_taken && halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs: one-hot action select in priority order branch > halt > stall > fetch
    always_comb begin
        do_branch_s = 1'b0;
        do_halt_s   = 1'b0;
        do_fetch_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (branch_taken) begin
                    do_branch_s = 1'b1;
                end else if (halt_req) begin
                    do_halt_s = 1'b1;
                end else if (!stall) begin
                    do_fetch_s = 1'b1;
                end else begin
                    do_fetch_s = 1'b0;
                end
            end
            ST_HALT: begin
                do_fetch_s = 1'b0;
            end
            default: begin
                do_fetch_s = 1'b0;
            end
        endcase
    end

    // PC, IF/ID register and sticky misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            valid_r <= 1'b0;
            ipc_r   <= 32'h0000_0000;
            instr_r <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (do_branch_s) begin
            pc_r    <= {branch_target[31:2], 2'b00};
            valid_r <= 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                err_r <= 1'b1;
            end
        end else if (do_halt_s) begin
            valid_r <= 1'b0;
        end else if (do_fetch_s) begin
            ipc_r   <= pc_r;
            instr_r <= imem_rdata;
            valid_r <= 1'b1;
            pc_r    <= pc_r + 32'd4;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] bubble_cnt_r;

    // Saturating counters; only redirects that kill a valid instruction count as bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_r  <= 32'h0000_0000;
            bubble_cnt_r <= 32'h0000_0000;
        end else begin
            if (do_fetch_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
                fetch_cnt_r <= fetch_cnt_r + 32'd1;
            end
            if (do_branch_s && valid_r && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_cnt_r;
    assign bubble_count = bubble_cnt_r;
`endif

    assign imem_addr    = pc_r;
    assign if_id_valid  = valid_r;
    assign if_id_pc     = ipc_r;
    assign if_id_instr  = instr_r;
    assign misalign_err = err_r;
    assign halted       = (state_r == ST_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed plan steps then random traffic vs. a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_id_valid, misalign_err, halted;
    logic [31:0] if_id_pc, if_id_instr;

    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic [31:0] w_addr, w_rdata, w_pc, w_instr;
    logic        w_valid, w_err, w_halted;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [31:0] m_pc, m_ipc, m_ins, m_fc, m_bc;
    logic        m_v, m_err, m_halt;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hF840_0281;
            32'h4:   return 32'h8B01_0022;
            32'h8:   return 32'hD100_0333;
            default: return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
        endcase
    endfunction

    assign imem_rdata = imem_f(imem_addr);
    assign w_rdata    = imem_f(w_addr);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, bubble_count, w_fc, w_bc;
`endif

    if_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .misalign_err(misalign_err), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .stall(w_zero), .branch_taken(w_zero),
        .branch_target(w_zero32), .halt_req(w_zero), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .if_id_valid(w_valid), .if_id_pc(w_pc),
        .if_id_instr(w_instr), .misalign_err(w_err), .halted(w_halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(w_fc), .bubble_count(w_bc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ipc = 32'h0; m_ins = 32'h0; m_v = 1'b0;
        m_err = 1'b0; m_halt = 1'b0; m_fc = 32'h0; m_bc = 32'h0;
    endtask

    // Rules applied to the inputs present before the edge
    task automatic model_edge();
        if (m_halt) return;
        if (branch_taken) begin
            if (m_v && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
            m_pc = branch_target & 32'hFFFF_FFFC;
            m_v = 1'b0;
            if (branch_target[1:0] != 2'b00) m_err = 1'b1;
        end else if (halt_req) begin
            m_halt = 1'b1;
            m_v = 1'b0;
        end else if (!stall) begin
            m_ipc = m_pc;
            m_ins = imem_f(m_pc);
            m_v = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_v});
        chk({tag, ".if_id_pc"}, if_id_pc, m_ipc);
        chk({tag, ".instr"}, if_id_instr, m_ins);
        chk({tag, ".misalign"}, {31'h0, misalign_err}, {31'h0, m_err});
        chk({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halt});
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".fetch_cnt"}, fetch_count, m_fc);
        chk({tag, ".bubble_cnt"}, bubble_count, m_bc);
`endif
    endtask

    task automatic step(input logic st, input logic br, input logic [31:0] bt, input logic hr,
                        input string tag);
        stall = st; branch_taken = br; branch_target = bt; halt_req = hr;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        step(1'b0, 1'b0, 32'h0, 1'b0, "seq1");
        chk("wrap.pc", w_addr, 32'h0);
        chk("wrap.if_id_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap.instr", w_instr, imem_f(32'hFFFF_FFFC));
        chk("wrap.valid", {31'h0, w_valid}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, "seq2");
        step(1'b0, 1'b0, 32'h0, 1'b0, "seq3");
        chk("seq.if_id_pc", if_id_pc, 32'h8);
        chk("seq.instr", if_id_instr, 32'hD100_0333);
        chk("seq.imem_addr", imem_addr, 32'hC);

        step(1'b1, 1'b0, 32'h0, 1'b0, "stall1");
        step(1'b1, 1'b0, 32'h0, 1'b0, "stall2");
        chk("stall.hold_pc", if_id_pc, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0, "resume1");
        step(1'b0, 1'b0, 32'h0, 1'b0, "resume2");
        chk("pre_branch.pc", imem_addr, 32'h14);

        step(1'b1, 1'b1, 32'h4, 1'b0, "br_stall");
        chk("br.pc", imem_addr, 32'h4);
        chk("br.bubble", {31'h0, if_id_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, "br_target");
        chk("br.target_instr", if_id_instr, 32'h8B01_0022);
`ifdef FETCH_PERF_CNT_EN
        chk("br.bubble_count", bubble_count, 32'h1);
`endif

        step(1'b0, 1'b1, 32'h13, 1'b0, "misalign");
        chk("mis.pc", imem_addr, 32'h10);
        chk("mis.flag", {31'h0, misalign_err}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, "mis_keep1");
        step(1'b0, 1'b0, 32'h0, 1'b0, "mis_keep2");
        chk("halt.pre_pc", imem_addr, 32'h18);

        step(1'b0, 1'b0, 32'h0, 1'b1, "halt");
        chk("halt.flag", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 4; i++) step(i[0], ~i[0], 32'h40, i[1], "halted_frozen");
        chk("halt.frozen_pc", imem_addr, 32'h18);
        mid_reset("halt_reset");

        step(1'b0, 1'b1, 32'h80, 1'b1, "br_and_halt");
        chk("br_halt.not_halted", {31'h0, halted}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic st, br, hr;
            logic [31:0] bt;
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            hr = ($urandom_range(0, 39) == 0);
            bt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step(st, br, bt, hr, "rand");
            if ($urandom_range(0, 49) == 0) mid_reset("rand_reset");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
